// File: rtl/aes_mc_pkg.sv
// Shared GF(2^8) arithmetic, FSM encoding and column helpers for the
// iterative MixColumns / InvMixColumns engine.
package aes_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Column j of the state lives MSB-first at bits [127-32j -: 32]
    function automatic logic [31:0] col_get(input logic [127:0] s, input int j);
        return s[127 - 32*j -: 32];
    endfunction

    function automatic bit cols_legal(input int c);
        return (c == 1) || (c == 2) || (c == 4);
    endfunction

endpackage

// File: rtl/aes_mc_column.sv
// Combinational single-column MixColumns (E_D=1) / InvMixColumns (E_D=0).
module aes_mc_column
    import aes_mc_pkg::*;
(
    input  logic        E_D,
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    always_comb begin
        if (E_D) begin
            col_out = {mul2(a0) ^ mul3(a1) ^ a2       ^ a3,
                       a0       ^ mul2(a1) ^ mul3(a2) ^ a3,
                       a0       ^ a1       ^ mul2(a2) ^ mul3(a3),
                       mul3(a0) ^ a1       ^ a2       ^ mul2(a3)};
        end else begin
            col_out = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                       mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                       muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                       mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
        end
    end

endmodule

// File: rtl/aes_mix_col_engine.sv
// Iterative, handshaked MixColumns/InvMixColumns over the full 128-bit state,
// COLS_PER_CYCLE columns per clock; final round passes the state through.
module aes_mix_col_engine
    import aes_mc_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int RND_W          = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             MC_IN_VALID,
    output logic             MC_IN_READY,
    input  logic [127:0]     MC_IN,
    input  logic             MC_E_D,
    input  logic [RND_W-1:0] MC_COUNT_ROUND,
    input  logic [RND_W-1:0] MC_FINAL_ROUND_COUNT,
    output logic             MC_OUT_VALID,
    input  logic             MC_OUT_READY,
    output logic [127:0]     MC_OUT,
    output logic             MC_BUSY
);

    localparam int N     = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!cols_legal(COLS_PER_CYCLE)) begin : g_bad_cols
        $error("aes_mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e          state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [127:0]       work, work_nx, work_upd;
    logic               mode, mode_nx;
    logic               accept, last_col;

    logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        aes_mc_column u_col (
            .E_D     (mode),
            .col_in  (col_in[i]),
            .col_out (col_out[i])
        );
    end

    // The column counter steers which slice of the working state each lane sees
    always_comb begin
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            col_in[i] = col_get(work, int'(cnt) * COLS_PER_CYCLE + i);
    end

    always_comb begin
        work_upd = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            work_upd[127 - 32*(int'(cnt) * COLS_PER_CYCLE + i) -: 32] = col_out[i];
    end

    assign MC_IN_READY  = (state == IDLE) || ((state == DONE) && MC_OUT_READY);
    assign MC_OUT_VALID = (state == DONE);
    assign MC_BUSY      = (state != IDLE);
    assign MC_OUT       = work;
    assign accept       = MC_IN_VALID && MC_IN_READY;
    assign last_col     = (cnt == CNT_W'(N - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        work_nx  = work;
        mode_nx  = mode;
        unique case (state)
            RUN: begin
                work_nx = work_upd;
                cnt_nx  = cnt + 1'b1;
                if (last_col) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end
            end
            DONE:    if (MC_OUT_READY) state_nx = IDLE;
            default: ;
        endcase
        // A new accept can coincide with the DONE release and overrides it
        if (accept) begin
            work_nx  = MC_IN;
            mode_nx  = MC_E_D;
            cnt_nx   = '0;
            state_nx = (MC_COUNT_ROUND == MC_FINAL_ROUND_COUNT) ? DONE : RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            work  <= work_nx;
            mode  <= mode_nx;
        end
    end

endmodule

// File: tb/tb_aes_mix_col_engine.sv
// Bench: three engines (C=1,2,4) side by side, vector table, directed
// handshake/reset sequences and a random encrypt/decrypt round-trip sweep.
module tb_aes_mix_col_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid [3];
    logic         in_ready [3];
    logic [127:0] in_data  [3];
    logic         ed       [3];
    logic [3:0]   rnd      [3];
    logic [3:0]   fin      [3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic [127:0] out_data [3];
    logic         busy     [3];

    int n_total, n_bad;
    logic [127:0] exp_q [3][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_col_engine #(.COLS_PER_CYCLE(1 << g), .RND_W(4)) u_dut (
            .CLK                  (clk),
            .RST_N                (rst_n),
            .MC_IN_VALID          (in_valid[g]),
            .MC_IN_READY          (in_ready[g]),
            .MC_IN                (in_data[g]),
            .MC_E_D               (ed[g]),
            .MC_COUNT_ROUND       (rnd[g]),
            .MC_FINAL_ROUND_COUNT (fin[g]),
            .MC_OUT_VALID         (out_valid[g]),
            .MC_OUT_READY         (out_ready[g]),
            .MC_OUT               (out_data[g]),
            .MC_BUSY              (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] s, input logic enc);
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        if (enc) begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        else     begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        for (int j = 0; j < 4; j++) begin
            for (int t = 0; t < 4; t++) a[t] = s[127 - 32*j - 8*t -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int t = 0; t < 4; t++) b ^= gmul(k[(t - rr) & 3], a[t]);
                r[127 - 32*j - 8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_exp(input logic [127:0] s, input logic enc,
                                             input logic [3:0] rc, input logic [3:0] fc);
        return (rc == fc) ? s : ref_mc(s, enc);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT event", nm);
    endtask

    task automatic scramble(input int g);
        ed[g]  = 1'($urandom);
        rnd[g] = 4'($urandom);
        fin[g] = 4'($urandom);
    endtask

    // Present a state, wait for the accept edge, then return at posedge+1
    task automatic drive_accept(input int g, input logic [127:0] d, input logic e,
                                input logic [3:0] rc, input logic [3:0] fc);
        int k = 0;
        in_valid[g] = 1'b1; in_data[g] = d; ed[g] = e; rnd[g] = rc; fin[g] = fc;
        forever begin
            @(negedge clk);
            if (in_ready[g]) break;
            if (++k > 50) begin fail_to($sformatf("accept%0d", g)); break; end
        end
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        in_data[g]  = rand128();
        scramble(g);
    endtask

    task automatic run_vec(input int g, input logic [127:0] d, input logic e,
                           input logic [3:0] rc, input logic [3:0] fc,
                           output logic [127:0] res, output int lat);
        out_ready[g] = 1'b1;
        drive_accept(g, d, e, rc, fc);
        lat = 0;
        while (!out_valid[g] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            scramble(g);
        end
        res = out_data[g];
        @(posedge clk); #1;
    endtask

    task automatic sweep_xfer(input int g, input logic [127:0] d, input logic e,
                              input logic [3:0] rc, input logic [3:0] fc,
                              output logic [127:0] res);
        int k = 0;
        res = '0;
        drive_accept(g, d, e, rc, fc);
        forever begin
            @(negedge clk);
            if (out_valid[g] && out_ready[g]) begin res = out_data[g]; break; end
            if (++k > 60) begin fail_to($sformatf("sweep%0d", g)); break; end
            @(posedge clk); #1;
            out_ready[g] = ($urandom_range(0, 3) != 0);
            scramble(g);
        end
        @(posedge clk); #1;
    endtask

    task automatic sweep(input int g, input int n);
        logic [127:0] x, y, z;
        logic [3:0]   rc, fc;
        for (int i = 0; i < n; i++) begin
            x  = rand128();
            rc = 4'($urandom_range(0, 3));
            fc = 4'($urandom_range(0, 3));
            sweep_xfer(g, x, 1'b1, rc, fc, y);
            sweep_xfer(g, y, 1'b0, rc, fc, z);
            chk($sformatf("roundtrip_c%0d", 1 << g), z, x);
        end
        out_ready[g] = 1'b1;
    endtask

    typedef struct {
        int           g;
        logic [127:0] din;
        logic         e;
        logic [3:0]   rc;
        logic [3:0]   fc;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [127:0] res, snap, y;
        int           lat, k;

        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; in_data[g] = '0; ed[g] = 1'b0;
            rnd[g] = '0; fin[g] = '0; out_ready[g] = 1'b1;
        end

        vt[0] = '{0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b1, 4'd1, 4'd10,
                  128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 4};
        vt[1] = '{2, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0, 4'd1, 4'd10,
                  128'hdb135345_f20a225c_01010101_2d26314c, 1};
        vt[2] = '{1, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 1'b1, 4'd3, 4'd10,
                  128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 2};
        vt[3] = '{1, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 1'b0, 4'd3, 4'd10,
                  128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 2};
        vt[4] = '{0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 4'd10, 4'd10,
                  128'h00112233_44556677_8899aabb_ccddeeff, 0};
        vt[5] = '{0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 4'd10, 4'd10,
                  128'h00112233_44556677_8899aabb_ccddeeff, 0};
        vt[6] = '{2, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b1, 4'd5, 4'd10,
                  128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1};
        vt[7] = '{1, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0, 4'd9, 4'd10,
                  128'hdb135345_f20a225c_01010101_2d26314c, 2};

        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    if (rst_n && out_valid[g] && out_ready[g]) begin
                        if (exp_q[g].size() == 0) begin
                            n_total++;
                            n_bad++;
                            $display("FAIL sb_c%0d: got=%h want=no output", 1 << g, out_data[g]);
                        end else begin
                            chk($sformatf("sb_c%0d", 1 << g), out_data[g], exp_q[g].pop_front());
                        end
                    end
                    if (rst_n && in_valid[g] && in_ready[g])
                        exp_q[g].push_back(ref_exp(in_data[g], ed[g], rnd[g], fin[g]));
                end
            end
            begin
                #900000;
                $display("FAIL watchdog: simulation still running at time limit");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #3;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_out_valid%0d", g), out_valid[g], 0);
            chk($sformatf("rst_out%0d", g), out_data[g], 0);
            chk($sformatf("rst_busy%0d", g), busy[g], 0);
            chk($sformatf("rst_in_ready%0d", g), in_ready[g], 1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table: value and accept-to-valid latency
        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i].g, vt[i].din, vt[i].e, vt[i].rc, vt[i].fc, res, lat);
            chk($sformatf("vec%0d_out", i), res, vt[i].dout);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end

        // Back-to-back bypass on C=1: one result per cycle
        out_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = 1'b1; in_data[0] = rand128(); ed[0] = 1'(i);
            rnd[0] = 4'd10; fin[0] = 4'd10;
            @(negedge clk);
            chk("b2b_in_ready", in_ready[0], 1);
            if (i > 0) chk("b2b_out_valid", out_valid[0], 1);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", out_valid[0], 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drained", out_valid[0], 0);
        @(posedge clk); #1;

        // Backpressure on C=2, then release and accept on the same edge
        out_ready[1] = 1'b0;
        drive_accept(1, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b1, 4'd1, 4'd10);
        k = 0;
        while (!out_valid[1] && k < 20) begin @(posedge clk); #1; k++; end
        if (!out_valid[1]) fail_to("bp_valid");
        snap = out_data[1];
        chk("bp_value", snap, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_stable", out_data[1], snap);
            chk("bp_valid_held", out_valid[1], 1);
            chk("bp_in_ready", in_ready[1], 0);
        end
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        y = rand128();
        in_valid[1] = 1'b1; in_data[1] = y; ed[1] = 1'b0; rnd[1] = 4'd2; fin[1] = 4'd10;
        @(negedge clk);
        chk("bp_release_ready", in_ready[1], 1);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        scramble(1);
        @(negedge clk);
        chk("bp_new_busy", busy[1], 1);
        chk("bp_new_running", out_valid[1], 0);
        k = 0;
        while (busy[1] && k < 20) begin @(posedge clk); #1; k++; end
        if (busy[1]) fail_to("bp_drain");

        // Asynchronous reset two RUN edges into a C=1 transaction
        drive_accept(0, rand128(), 1'b1, 4'd1, 4'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid[0], 0);
        chk("mid_rst_out", out_data[0], 0);
        chk("mid_rst_in_ready", in_ready[0], 1);
        chk("mid_rst_busy", busy[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) exp_q[g].delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid[0], 0);
        end
        @(posedge clk); #1;
        run_vec(0, vt[0].din, 1'b1, 4'd1, 4'd10, res, lat);
        chk("post_rst_out", res, vt[0].dout);
        chk("post_rst_lat", lat, 4);

        // Random round trips, inputs toggled while running, all widths in parallel
        fork
            sweep(0, 1500);
            sweep(1, 1500);
            sweep(2, 1500);
        join
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++)
            chk($sformatf("sb_empty%0d", g), exp_q[g].size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
